// File: rtl/vscale_iter_shifter.sv
// Iterative one-bit-per-cycle shifter for SLL/SRL/SRA with a req/resp handshake.
// Width comes from XPR_LEN; a local default keeps the file self-contained.
`ifndef XPR_LEN
`define XPR_LEN 32
`endif

module vscale_iter_shifter (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [`XPR_LEN-1:0] req_src_a,
    input  logic [`XPR_LEN-1:0] req_src_b,
    input  logic                kill,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [`XPR_LEN-1:0] resp_result
);

    localparam int unsigned XprLen = `XPR_LEN;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSra = 2'b10;

    state_e              r_state;
    state_e              w_state_next;
    logic [XprLen-1:0]   r_data;
    logic [XprLen-1:0]   w_data_next;
    logic [1:0]          r_op;
    logic [1:0]          w_op_next;
    logic [4:0]          r_count;
    logic [4:0]          w_count_next;
    logic [XprLen-1:0]   w_shift_one;
    logic                w_accept;
    logic                w_unused_src_b;

    // Only the shift amount field of source B matters.
    assign w_unused_src_b = ^req_src_b[XprLen-1:5];

    assign req_ready   = reset_n & (r_state == StIdle) & ~kill;
    assign w_accept    = req_valid & req_ready;
    assign resp_valid  = (r_state == StDone);
    assign resp_result = r_data;

    // Reserved op falls through to the logical right shift.
    always_comb begin
        w_shift_one = {1'b0, r_data[XprLen-1:1]};
        if (r_op == OpSll) begin
            w_shift_one = {r_data[XprLen-2:0], 1'b0};
        end else if (r_op == OpSra) begin
            w_shift_one = {r_data[XprLen-1], r_data[XprLen-1:1]};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_op_next    = r_op;
        w_count_next = r_count;
        if (kill) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        w_state_next = StBusy;
                        w_data_next  = req_src_a;
                        w_op_next    = req_op;
                        w_count_next = req_src_b[4:0];
                    end
                end
                StBusy: begin
                    if (r_count == 5'd0) begin
                        w_state_next = StDone;
                    end else begin
                        w_data_next  = w_shift_one;
                        w_count_next = r_count - 5'd1;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        w_state_next = StIdle;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_data  <= '0;
            r_op    <= 2'b00;
            r_count <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_op    <= w_op_next;
            r_count <= w_count_next;
        end
    end

endmodule
